// File: rtl/hps_ext_chan.sv
// hps_ext_chan: HPS extension-bus endpoint with CHANNELS byte-stream channels.
//
// Each channel owns a DEPTH-entry core->HPS FIFO with a sticky overflow flag
// and an unbuffered HPS->core byte strobe path. Optional IDE register
// passthrough is compiled in when the macro HPS_EXT_IDE_EN is defined.
//
// Parameters:
//   CHANNELS  number of byte channels (1..4)
//   DEPTH     FIFO entries per channel (power of 2, 4..64)
//   CMD_BASE  command code of channel 0 read; channel ch uses
//             CMD_BASE+2ch (read) and CMD_BASE+2ch+1 (write)
//
// Ports:
//   clk_sys     system clock, rising edge
//   reset_n     asynchronous active-low reset
//   EXT_BUS     [15:0] io_dout (out), [31:16] io_din, [32] io_dout_en (out),
//               [33] io_strobe, [34] io_enable, [35] fp_enable
//   out_data    core->HPS byte per channel, channel ch at [8ch+7:8ch]
//   out_strobe  rising edge pushes out_data of that channel
//   in_data     HPS->core byte per channel
//   in_strobe   one-cycle pulse per delivered byte
//   ide_*       IDE passthrough (tied to 0 without HPS_EXT_IDE_EN)

module hps_ext_chan #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 16,
    parameter logic [7:0]  CMD_BASE = 8'h04
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    inout  wire  [35:0]           EXT_BUS,
    input  logic [8*CHANNELS-1:0] out_data,
    input  logic [CHANNELS-1:0]   out_strobe,
    output logic [8*CHANNELS-1:0] in_data,
    output logic [CHANNELS-1:0]   in_strobe,
    input  logic [15:0]           ide_din,
    output logic [15:0]           ide_dout,
    output logic [4:0]            ide_addr,
    output logic                  ide_rd,
    output logic                  ide_wr,
    input  logic [5:0]            ide_req
);

    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam logic [7:0]  CmdLast = CMD_BASE + 8'(2 * CHANNELS) - 8'd1;

    // ------------------------------------------------------------------
    // Bus breakout
    // ------------------------------------------------------------------
    logic [15:0] io_din;
    logic        io_strobe;
    logic        io_enable;
    logic        fp_enable;
    logic        enable;

    logic [15:0] io_dout_q, io_dout_d;
    logic        io_dout_en_q, io_dout_en_d;

    assign io_din    = EXT_BUS[31:16];
    assign io_strobe = EXT_BUS[33];
    assign io_enable = EXT_BUS[34];
    assign fp_enable = EXT_BUS[35];
    assign enable    = io_enable | fp_enable;

    assign EXT_BUS[15:0] = io_dout_q;
    assign EXT_BUS[32]   = io_dout_en_q;

    // ------------------------------------------------------------------
    // Transaction state
    // ------------------------------------------------------------------
    logic [3:0] wc_q, wc_d;
    logic [7:0] cmd_q, cmd_d;
    logic       fp_q, fp_d;

    logic [7:0] cmd_new;
    logic       new_claim_chan;
    logic [7:0] cmd_off;
    logic       cmd_chan;
    logic       cmd_wr;
    logic [1:0] cmd_ch;
    logic       data_word;

    assign cmd_new        = io_din[7:0];
    assign new_claim_chan = (cmd_new >= CMD_BASE) && (cmd_new <= CmdLast);

    // Channel ops are only honoured for commands latched outside fp mode.
    assign cmd_off   = cmd_q - CMD_BASE;
    assign cmd_chan  = !fp_q && (cmd_q >= CMD_BASE) && (cmd_q <= CmdLast);
    assign cmd_wr    = cmd_off[0];
    assign cmd_ch    = cmd_off[2:1];
    assign data_word = enable && io_strobe && (wc_q != 4'd0);

    logic unused_cmd_off;
    assign unused_cmd_off = ^cmd_off[7:3];

    // ------------------------------------------------------------------
    // Channel FIFO state
    // ------------------------------------------------------------------
    logic [7:0]          mem_q    [CHANNELS][DEPTH];
    logic [PtrW-1:0]     wr_ptr_q [CHANNELS];
    logic [PtrW-1:0]     rd_ptr_q [CHANNELS];
    logic [CntW-1:0]     cnt_q    [CHANNELS];
    logic [CHANNELS-1:0] ovf_q;
    logic [CHANNELS-1:0] ostb_q;
    logic [CHANNELS-1:0] push_q;
    logic [8*CHANNELS-1:0] push_data_q;

    logic [8*CHANNELS-1:0] in_data_q;
    logic [CHANNELS-1:0]   in_strobe_q;

    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] status_rd;
    logic [CHANNELS-1:0] deliver;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] do_push;
    logic [7:0]          sel_head;
    logic [CntW-1:0]     sel_cnt;
    logic                sel_ovf;

    // Decode the current data word against the latched command.
    always_comb begin
        pop       = '0;
        status_rd = '0;
        deliver   = '0;
        sel_head  = '0;
        sel_cnt   = '0;
        sel_ovf   = 1'b0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            if (cmd_ch == 2'(ch)) begin
                sel_head = mem_q[ch][rd_ptr_q[ch]];
                sel_cnt  = cnt_q[ch];
                sel_ovf  = ovf_q[ch];
                if (data_word && cmd_chan) begin
                    if (cmd_wr) begin
                        deliver[ch] = 1'b1;
                    end else if (wc_q == 4'd1) begin
                        status_rd[ch] = 1'b1;
                    end else if (cnt_q[ch] != '0) begin
                        pop[ch] = 1'b1;
                    end
                end
            end
        end
    end

    // A push into a full FIFO is still accepted when a pop frees a slot
    // in the same cycle.
    always_comb begin
        full    = '0;
        do_push = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            full[ch]    = (cnt_q[ch] == CntW'(DEPTH));
            do_push[ch] = push_q[ch] && (!full[ch] || pop[ch]);
        end
    end

    always_ff @(posedge clk_sys) begin
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            if (do_push[ch]) begin
                mem_q[ch][wr_ptr_q[ch]] <= push_data_q[8*ch +: 8];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ostb_q      <= '0;
            push_q      <= '0;
            push_data_q <= '0;
            ovf_q       <= '0;
            in_data_q   <= '0;
            in_strobe_q <= '0;
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                wr_ptr_q[ch] <= '0;
                rd_ptr_q[ch] <= '0;
                cnt_q[ch]    <= '0;
            end
        end else begin
            ostb_q      <= out_strobe;
            // Edge is registered with its data; the push lands a cycle later.
            push_q      <= out_strobe & ~ostb_q;
            push_data_q <= out_data;
            in_strobe_q <= deliver;
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                if (do_push[ch]) begin
                    wr_ptr_q[ch] <= wr_ptr_q[ch] + PtrW'(1);
                end
                if (pop[ch]) begin
                    rd_ptr_q[ch] <= rd_ptr_q[ch] + PtrW'(1);
                end
                if (do_push[ch] && !pop[ch]) begin
                    cnt_q[ch] <= cnt_q[ch] + CntW'(1);
                end else if (pop[ch] && !do_push[ch]) begin
                    cnt_q[ch] <= cnt_q[ch] - CntW'(1);
                end
                // A drop in the same cycle as a status read stays visible.
                if (push_q[ch] && !do_push[ch]) begin
                    ovf_q[ch] <= 1'b1;
                end else if (status_rd[ch]) begin
                    ovf_q[ch] <= 1'b0;
                end
                if (deliver[ch]) begin
                    in_data_q[8*ch +: 8] <= io_din[7:0];
                end
            end
        end
    end

    assign in_data   = in_data_q;
    assign in_strobe = in_strobe_q;

    // ------------------------------------------------------------------
    // IDE passthrough
    // ------------------------------------------------------------------
    logic        ide_claim_new;
    logic        ide_word0_hit;
    logic [15:0] ide_word0_data;
    logic        ide_rd_word;
    logic [15:0] ide_rd_data;

`ifdef HPS_EXT_IDE_EN
    logic [15:0] ide_dout_q;
    logic [4:0]  ide_addr_q;
    logic        ide_rd_q;
    logic        ide_wr_q;
    logic        ide_cs_q;
    logic        ide_access;
    logic        ide_cmd_rw;

    assign ide_claim_new  = (cmd_new >= 8'h61) && (cmd_new <= 8'h63);
    assign ide_word0_hit  = (cmd_new == 8'h63);
    assign ide_word0_data = {4'hE, 6'b0, ide_req};
    assign ide_cmd_rw     = !fp_q && ((cmd_q == 8'h61) || (cmd_q == 8'h62));
    assign ide_access     = enable && io_strobe && ide_cmd_rw && (wc_q >= 4'd3) && ide_cs_q;
    assign ide_rd_word    = ide_access && (cmd_q == 8'h62);
    assign ide_rd_data    = ide_din;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ide_dout_q <= '0;
            ide_addr_q <= '0;
            ide_rd_q   <= 1'b0;
            ide_wr_q   <= 1'b0;
            ide_cs_q   <= 1'b0;
        end else begin
            ide_rd_q <= 1'b0;
            ide_wr_q <= 1'b0;
            // Auto-increment within a register bank after each access.
            if ((ide_rd_q || ide_wr_q) && (ide_addr_q[3:0] != 4'hF)) begin
                ide_addr_q <= ide_addr_q + 5'd1;
            end
            if (enable && io_strobe) begin
                ide_dout_q <= io_din;
                if (wc_q == 4'd0) begin
                    ide_cs_q <= 1'b0;
                end else if (wc_q == 4'd1 && ide_cmd_rw) begin
                    ide_addr_q <= {io_din[8], io_din[3:0]};
                    ide_cs_q   <= (io_din[15:9] == 7'b1111000);
                end
                if (ide_access) begin
                    ide_wr_q <= (cmd_q == 8'h61);
                    ide_rd_q <= (cmd_q == 8'h62);
                end
            end
        end
    end

    assign ide_dout = ide_dout_q;
    assign ide_addr = ide_addr_q;
    assign ide_rd   = ide_rd_q;
    assign ide_wr   = ide_wr_q;
`else
    assign ide_claim_new  = 1'b0;
    assign ide_word0_hit  = 1'b0;
    assign ide_word0_data = '0;
    assign ide_rd_word    = 1'b0;
    assign ide_rd_data    = '0;

    assign ide_dout = '0;
    assign ide_addr = '0;
    assign ide_rd   = 1'b0;
    assign ide_wr   = 1'b0;

    logic unused_ide;
    assign unused_ide = ^{ide_din, ide_req};
`endif

    // ------------------------------------------------------------------
    // Word counter and response register
    // ------------------------------------------------------------------
    always_comb begin
        wc_d         = wc_q;
        cmd_d        = cmd_q;
        fp_d         = fp_q;
        io_dout_d    = io_dout_q;
        io_dout_en_d = io_dout_en_q;
        if (!enable) begin
            wc_d         = '0;
            io_dout_d    = '0;
            io_dout_en_d = 1'b0;
        end else if (io_strobe) begin
            if (wc_q != 4'hF) begin
                wc_d = wc_q + 4'd1;
            end
            if (wc_q == 4'd0) begin
                cmd_d = cmd_new;
                fp_d  = fp_enable;
                if (fp_enable) begin
                    io_dout_en_d = (io_din == 16'h0000);
                    io_dout_d    = 16'hA000 | 16'(CHANNELS);
                end else begin
                    io_dout_en_d = new_claim_chan || ide_claim_new;
                    io_dout_d    = ide_word0_hit ? ide_word0_data : 16'h0000;
                end
            end else if (cmd_chan && !cmd_wr) begin
                if (wc_q == 4'd1) begin
                    io_dout_d = {4'hA, 3'b0, sel_ovf, 1'b0, 7'(sel_cnt)};
                end else if (sel_cnt != '0) begin
                    io_dout_d = {7'b0, 1'b1, sel_head};
                end else begin
                    io_dout_d = 16'h0000;
                end
            end else if (ide_rd_word) begin
                io_dout_d = ide_rd_data;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wc_q         <= '0;
            cmd_q        <= '0;
            fp_q         <= 1'b0;
            io_dout_q    <= '0;
            io_dout_en_q <= 1'b0;
        end else begin
            wc_q         <= wc_d;
            cmd_q        <= cmd_d;
            fp_q         <= fp_d;
            io_dout_q    <= io_dout_d;
            io_dout_en_q <= io_dout_en_d;
        end
    end

endmodule

// File: tb/tb_hps_ext_chan.sv
`timescale 1ns/1ps
module tb_hps_ext_chan;

    localparam int unsigned CH       = 2;
    localparam int unsigned DEPTH    = 4;
    localparam logic [7:0]  CMD_BASE = 8'h04;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic [15:0]     io_din    = '0;
    logic            io_strobe = 1'b0;
    logic            io_enable = 1'b0;
    logic            fp_enable = 1'b0;
    logic [8*CH-1:0] out_data  = '0;
    logic [CH-1:0]   out_strobe = '0;
    logic [15:0]     ide_din   = 16'h1234;
    logic [5:0]      ide_req   = 6'h00;

    wire  [35:0]     ext_bus;
    wire  [8*CH-1:0] in_data;
    wire  [CH-1:0]   in_strobe;
    wire  [15:0]     ide_dout;
    wire  [4:0]      ide_addr;
    wire             ide_rd;
    wire             ide_wr;
    wire  [15:0]     io_dout;
    wire             io_dout_en;

    assign ext_bus[31:16] = io_din;
    assign ext_bus[33]    = io_strobe;
    assign ext_bus[34]    = io_enable;
    assign ext_bus[35]    = fp_enable;
    assign io_dout        = ext_bus[15:0];
    assign io_dout_en     = ext_bus[32];

    hps_ext_chan #(
        .CHANNELS (CH),
        .DEPTH    (DEPTH),
        .CMD_BASE (CMD_BASE)
    ) u_dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .EXT_BUS    (ext_bus),
        .out_data   (out_data),
        .out_strobe (out_strobe),
        .in_data    (in_data),
        .in_strobe  (in_strobe),
        .ide_din    (ide_din),
        .ide_dout   (ide_dout),
        .ide_addr   (ide_addr),
        .ide_rd     (ide_rd),
        .ide_wr     (ide_wr),
        .ide_req    (ide_req)
    );

    // Reference model: one queue per channel plus sticky overflow flags.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       ovf_m     [CH];
    logic [7:0] in_data_m [CH];

    int vectors    = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count(input int ch);
        if (ch == 0) return q0.size();
        return q1.size();
    endfunction

    function automatic logic [15:0] m_status(input int ch);
        return 16'hA000 | (ovf_m[ch] ? 16'h0100 : 16'h0000) | 16'(m_count(ch));
    endfunction

    task automatic m_push(input int ch, input logic [7:0] b);
        if (m_count(ch) >= int'(DEPTH)) ovf_m[ch] = 1'b1;
        else if (ch == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    task automatic m_pop(input int ch, output logic [15:0] word);
        if (m_count(ch) == 0) word = 16'h0000;
        else if (ch == 0) word = {8'h01, q0.pop_front()};
        else word = {8'h01, q1.pop_front()};
    endtask

    task automatic m_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < int'(CH); i++) begin
            ovf_m[i]     = 1'b0;
            in_data_m[i] = 8'h00;
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic bus_word(input logic [15:0] d);
        io_din    = d;
        io_strobe = 1'b1;
        tick();
        io_strobe = 1'b0;
    endtask

    task automatic bus_end();
        io_enable = 1'b0;
        fp_enable = 1'b0;
        tick();
        check_eq("idle_bus", {15'b0, io_dout_en, io_dout}, 32'h0);
        check_eq("idle_in_strobe", 32'(in_strobe), 32'h0);
    endtask

    task automatic push(input int ch, input logic [7:0] b);
        out_data[8*ch +: 8] = b;
        out_strobe[ch]      = 1'b1;
        tick();
        out_strobe[ch]      = 1'b0;
        tick();
        m_push(ch, b);
    endtask

    task automatic read_txn(input int ch, input int ndata);
        logic [15:0] exp;
        io_enable = 1'b1;
        bus_word(16'(CMD_BASE) + 16'(2 * ch));
        check_eq("rd_claim", 32'(io_dout_en), 32'h1);
        bus_word(16'(16'($urandom)));
        exp = m_status(ch);
        ovf_m[ch] = 1'b0;
        check_eq("rd_status", 32'(io_dout), 32'(exp));
        for (int i = 0; i < ndata; i++) begin
            bus_word(16'($urandom));
            m_pop(ch, exp);
            check_eq("rd_data", 32'(io_dout), 32'(exp));
        end
        bus_end();
    endtask

    // Byte i of the transfer is bytes[8i+7:8i].
    task automatic write_txn(input int ch, input int n, input logic [31:0] bytes);
        logic [7:0] b;
        io_enable = 1'b1;
        bus_word(16'(CMD_BASE) + 16'(2 * ch + 1));
        check_eq("wr_claim", 32'(io_dout_en), 32'h1);
        for (int i = 0; i < n; i++) begin
            b = bytes[8*i +: 8];
            bus_word({8'h00, b});
            in_data_m[ch] = b;
            check_eq("wr_strobe", 32'(in_strobe), 32'(1 << ch));
            check_eq("wr_data", 32'(in_data), {16'h0, in_data_m[1], in_data_m[0]});
            tick();
            check_eq("wr_pulse_end", 32'(in_strobe), 32'h0);
        end
        bus_end();
    endtask

    // Push is timed to land on the same edge as the popping data word.
    task automatic overlap_word(input int ch, input logic [7:0] b);
        logic [15:0] exp;
        out_data[8*ch +: 8] = b;
        out_strobe[ch]      = 1'b1;
        tick();
        out_strobe[ch]      = 1'b0;
        bus_word(16'h0000);
        m_pop(ch, exp);
        m_push(ch, b);
        check_eq("ovl_data", 32'(io_dout), 32'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp;
        m_reset();
        tick();
        tick();
        check_eq("rst_bus", {15'b0, io_dout_en, io_dout}, 32'h0);
        check_eq("rst_in", {14'b0, in_strobe, in_data}, 32'h0);
        check_eq("rst_ide", {9'b0, ide_rd, ide_wr, ide_addr, ide_dout}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Two bytes on channel 1, then a four-word read.
        push(1, 8'h1C);
        push(1, 8'h2A);
        read_txn(1, 3);

        // Overflow: six pushes into a four-deep FIFO.
        for (int i = 0; i < 6; i++) push(0, 8'(8'h30 + i));
        read_txn(0, 5);
        read_txn(0, 0);

        // Push/pop overlap across the pointer wrap.
        push(0, 8'h51);
        push(0, 8'h52);
        io_enable = 1'b1;
        bus_word(16'(CMD_BASE));
        bus_word(16'h0000);
        exp = m_status(0);
        check_eq("ovl_status", 32'(io_dout), 32'(exp));
        overlap_word(0, 8'h53);
        overlap_word(0, 8'h54);
        overlap_word(0, 8'h55);
        bus_end();
        read_txn(0, 3);

        // Writes on channel 0; channel 1 must stay untouched.
        write_txn(0, 2, 32'h0000_12F0);

        // Front-panel probe, then an unclaimed command.
        fp_enable = 1'b1;
        bus_word(16'h0000);
        check_eq("fp_claim", 32'(io_dout_en), 32'h1);
        check_eq("fp_dout", 32'(io_dout), 32'hA000 | CH);
        bus_end();
        io_enable = 1'b1;
        bus_word(16'h0040);
        check_eq("unk_claim", 32'(io_dout_en), 32'h0);
        bus_word(16'h0000);
        bus_word(16'h0000);
        check_eq("unk_no_pulse", 32'(in_strobe), 32'h0);
        bus_end();

        // Randomized mix.
        for (int it = 0; it < 80; it++) begin
            int kind;
            int ch;
            kind = int'($urandom_range(0, 4));
            ch   = int'($urandom_range(0, CH - 1));
            if (kind <= 1) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) push(ch, 8'($urandom));
            end else if (kind <= 3) begin
                read_txn(ch, int'($urandom_range(0, 6)));
            end else begin
                write_txn(ch, int'($urandom_range(1, 4)), $urandom);
            end
        end

        // Reset in the middle of a read.
        push(0, 8'hA1);
        push(0, 8'hA2);
        push(0, 8'hA3);
        write_txn(1, 1, 32'h0000_0077);
        io_enable = 1'b1;
        bus_word(16'(CMD_BASE));
        bus_word(16'h0000);
        exp = m_status(0);
        ovf_m[0] = 1'b0;
        check_eq("mid_status", 32'(io_dout), 32'(exp));
        bus_word(16'h0000);
        m_pop(0, exp);
        check_eq("mid_data", 32'(io_dout), 32'(exp));
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_bus", {15'b0, io_dout_en, io_dout}, 32'h0);
        check_eq("arst_in", {14'b0, in_strobe, in_data}, 32'h0);
        check_eq("arst_ide", {9'b0, ide_rd, ide_wr, ide_addr, ide_dout}, 32'h0);
        m_reset();
        io_enable = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_eq("post_rst_bus", {15'b0, io_dout_en, io_dout}, 32'h0);
        read_txn(0, 1);
        read_txn(1, 1);

`ifdef HPS_EXT_IDE_EN
        ide_req   = 6'h21;
        io_enable = 1'b1;
        bus_word(16'h0063);
        check_eq("ide_claim", 32'(io_dout_en), 32'h1);
        check_eq("ide_req", 32'(io_dout), 32'hE021);
        bus_end();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
